dec_secded: RTL and testbench
=============================

DEC_SECDED -- requirements
Module: dec_secded

Interface
REQ-001 SHALL have parameter MAX_CODEWORD_WIDTH, default 32, the widest codeword in bits.
REQ-002 SHALL have parameter MAX_INFO_WIDTH, default 26, the widest information word in bits.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the width of each error statistics counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: data_in and work_mod are valid this cycle.
REQ-007 SHALL have port data_in, input, MAX_CODEWORD_WIDTH bits: received codeword, LSB-aligned.
REQ-008 SHALL have port work_mod, input, 2 bits: 01 selects n=8/k=4, 10 selects n=16/k=11, 11 selects n=32/k=26, and 00 is illegal.
REQ-009 SHALL have port clr_cnt, input, 1 bit: synchronous clear of both counters.
REQ-010 SHALL have port out_valid, output, 1 bit: data_out and num_of_errors are valid.
REQ-011 SHALL have port data_out, output, MAX_CODEWORD_WIDTH bits: corrected info in [k-1:0], with upper bits 0.
REQ-012 SHALL have port num_of_errors, output, 2 bits: 0 means clean, 1 means corrected, 2 means uncorrectable, 3 means illegal mode.
REQ-013 SHALL have port cnt_corrected, output, CNT_WIDTH bits: saturating count of words with num_of_errors=1.
REQ-014 SHALL have port cnt_uncorr, output, CNT_WIDTH bits: saturating count of words with num_of_errors=2.

Function
REQ-015 SHALL use this code layout (extended Hamming): codeword bit j (j=0..n-2) is Hamming position j+1; parity sits at positions 1,2,4,8,16; bit n-1 is overall parity (XOR of bits 0..n-2); info bit 0 upward fills non-power-of-two positions in ascending order.
REQ-016 SHALL mask data_in bits [MAX_CODEWORD_WIDTH-1:n] to 0 before any computation, so padding never affects results.
REQ-017 Stage 1 SHALL register the masked codeword, the syndrome (XOR of position indices of all set bits in 1..n-1, 5 bits), the overall parity check (XOR of bits 0..n-1), the mode and a valid bit.
REQ-018 Stage 2 SHALL register data_out, num_of_errors and out_valid, giving a fixed latency of 2 cycles (in_valid at edge t produces out_valid at edge t+2), full throughput with no stalls.
REQ-019 If syndrome=0 and parity=0, stage 2 SHALL output num_of_errors=0 and the info unchanged.
REQ-020 If syndrome!=0 and parity=1, stage 2 SHALL flip codeword bit (syndrome-1), set num_of_errors=1 and output the corrected info.
REQ-021 If syndrome=0 and parity=1, the error is in the overall-parity bit: stage 2 SHALL set num_of_errors=1 and output the info unchanged.
REQ-022 If syndrome!=0 and parity=0, stage 2 SHALL set num_of_errors=2 and output the uncorrected extracted info.
REQ-023 When work_mod=00, stage 2 SHALL set num_of_errors=3 and data_out=0; counters SHALL NOT change.
REQ-024 Mode SHALL be captured per word, so mode changes on consecutive cycles are decoded independently.
REQ-025 When out_valid=0, data_out and num_of_errors SHALL hold their previous values.
REQ-026 Counters SHALL increment on the cycle out_valid rises with the matching num_of_errors, and SHALL saturate at all-ones.
REQ-027 clr_cnt SHALL take priority over a simultaneous increment: the counter becomes 0, not 1.

Reset
REQ-028 When rst=0, all pipeline valids, out_valid, data_out, num_of_errors and both counters SHALL go to 0 immediately.
REQ-029 A reset mid-operation SHALL drop in-flight words with no out_valid for them; decoding resumes with the first in_valid after release.

Structure
REQ-030 The mode encodings, the per-mode n/k/parity-count constants and the num_of_errors codes SHALL live in a shared package used by both the encoder and this decoder.
REQ-031 The syndrome/parity computation SHALL be one sub-module, dec_syndrome (combinational, mode-parameterised), instantiated in stage 1.

Verification
REQ-032 Mode 01, data_in=32'h55 -> after 2 cycles data_out=4'hB, num_of_errors=0.
REQ-033 Mode 01, data_in=32'h45 (bit 4 flipped) -> data_out=4'hB, num_of_errors=1, cnt_corrected increments by 1.
REQ-034 Mode 01, data_in=32'hD5 (parity bit flipped) -> data_out=4'hB, num_of_errors=1.
REQ-035 Mode 01, data_in=32'h56 (bits 0,1 flipped) -> num_of_errors=2, cnt_uncorr increments by 1.
REQ-036 Back-to-back: mode 01 32'hFFFFFF55, then mode 11 32'h0, then mode 00 -> outputs B/0, 0/0, 0/3 on three consecutive cycles.
REQ-037 Reset asserted one cycle after in_valid -> no out_valid, counters 0; with clr_cnt asserted alongside an increment, the counter reads 0.

Source files
------------

// File: rtl/dec_secded_pkg.sv
// Shared SECDED constants: mode encodings, per-mode code geometry
// and the num_of_errors result codes.
package dec_secded_pkg;

    localparam logic [1:0] MODE_ILL = 2'b00;
    localparam logic [1:0] MODE_8   = 2'b01;
    localparam logic [1:0] MODE_16  = 2'b10;
    localparam logic [1:0] MODE_32  = 2'b11;

    localparam int N_8  = 8;
    localparam int K_8  = 4;
    localparam int P_8  = 3;
    localparam int N_16 = 16;
    localparam int K_16 = 11;
    localparam int P_16 = 4;
    localparam int N_32 = 32;
    localparam int K_32 = 26;
    localparam int P_32 = 5;

    localparam int SYN_W = P_32;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CORR   = 2'd1;
    localparam logic [1:0] ERR_UNCORR = 2'd2;
    localparam logic [1:0] ERR_MODE   = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [1:0]       mode;
        logic [SYN_W-1:0] syn;
        logic             par;
    } s1_meta_t;

    function automatic int mode_n(input logic [1:0] mode);
        case (mode)
            MODE_8:  return N_8;
            MODE_16: return N_16;
            MODE_32: return N_32;
            default: return 0;
        endcase
    endfunction

    function automatic int mode_k(input logic [1:0] mode);
        case (mode)
            MODE_8:  return K_8;
            MODE_16: return K_16;
            MODE_32: return K_32;
            default: return 0;
        endcase
    endfunction

    function automatic int mode_p(input logic [1:0] mode);
        case (mode)
            MODE_8:  return P_8;
            MODE_16: return P_16;
            MODE_32: return P_32;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/dec_syndrome.sv
// Hamming syndrome and overall parity of a masked codeword
// for the selected code mode.
module dec_syndrome
    import dec_secded_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]     cw,
    input  logic [1:0]       mode,
    output logic [SYN_W-1:0] syn,
    output logic             par
);

    int n;

    always_comb begin
        n   = mode_n(mode);
        syn = '0;
        // bit n-1 is the overall parity bit, not a Hamming position
        for (int j = 0; j < W - 1; j++) begin
            if (cw[j] && (j < n - 1)) begin
                syn = syn ^ SYN_W'(j + 1);
            end
        end
        syn = syn & SYN_W'((1 << mode_p(mode)) - 1);
        par = ^cw;
    end

endmodule

// File: rtl/dec_secded.sv
// Two-stage extended-Hamming SECDED decoder with per-word mode
// selection and saturating error statistics.
module dec_secded
    import dec_secded_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    work_mod,
    input  logic                          clr_cnt,
    output logic                          out_valid,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    num_of_errors,
    output logic [CNT_WIDTH-1:0]          cnt_corrected,
    output logic [CNT_WIDTH-1:0]          cnt_uncorr
);

    localparam int W = MAX_CODEWORD_WIDTH;

    logic [W-1:0]              cw_m;
    logic [SYN_W-1:0]          syn;
    logic                      par;
    logic [W-1:0]              s1_cw;
    s1_meta_t                  s1;
    logic                      legal;
    logic [SYN_W-1:0]          flip_ix;
    logic [W-1:0]              fixed;
    logic [MAX_INFO_WIDTH-1:0] info;
    logic [1:0]                err;
    logic [W-1:0]              dout_nx;
    int                        k;
    logic                      unused_fixed;

    always_comb begin
        cw_m = data_in;
        for (int j = 0; j < W; j++) begin
            if (j >= mode_n(work_mod)) begin
                cw_m[j] = 1'b0;
            end
        end
    end

    dec_syndrome #(
        .W(W)
    ) u_syn (
        .cw  (cw_m),
        .mode(work_mod),
        .syn (syn),
        .par (par)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= '0;
            s1_cw <= '0;
        end else begin
            s1 <= '{valid: in_valid, mode: work_mod,
                    syn: syn, par: par};
            s1_cw <= cw_m;
        end
    end

    always_comb begin
        legal   = (s1.mode != MODE_ILL);
        flip_ix = s1.syn - 1'b1;
        fixed   = s1_cw;
        err     = ERR_UNCORR;
        unique case (1'b1)
            !legal: err = ERR_MODE;
            legal && s1.syn == '0 && !s1.par: err = ERR_NONE;
            legal && s1.syn != '0 && s1.par: begin
                fixed[flip_ix] = ~fixed[flip_ix];
                err = ERR_CORR;
            end
            legal && s1.syn == '0 && s1.par: err = ERR_CORR;
            default: err = ERR_UNCORR;
        endcase
    end

    // Info bits sit at non-power-of-two positions; index is the count
    // of such positions below p.
    for (genvar p = 3; p < W; p++) begin : g_info
        if (((p & (p - 1)) != 0) &&
            ((p - $clog2(p + 1) - 1) < MAX_INFO_WIDTH)) begin : g_bit
            assign info[p - $clog2(p + 1) - 1] = fixed[p - 1];
        end
    end

    assign unused_fixed = ^fixed;

    always_comb begin
        k       = mode_k(s1.mode);
        dout_nx = '0;
        if (err != ERR_MODE) begin
            dout_nx = W'(info & MAX_INFO_WIDTH'((1 << k) - 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            data_out      <= '0;
            num_of_errors <= ERR_NONE;
        end else begin
            out_valid <= s1.valid;
            if (s1.valid) begin
                data_out      <= dout_nx;
                num_of_errors <= err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_corrected <= '0;
            cnt_uncorr    <= '0;
        end else if (clr_cnt) begin
            cnt_corrected <= '0;
            cnt_uncorr    <= '0;
        end else if (s1.valid) begin
            if (err == ERR_CORR && cnt_corrected != '1) begin
                cnt_corrected <= cnt_corrected + 1'b1;
            end
            if (err == ERR_UNCORR && cnt_uncorr != '1) begin
                cnt_uncorr <= cnt_uncorr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dec_secded.sv
// Scoreboard bench for dec_secded: directed vectors, reset/clear
// corner cases and randomly corrupted codewords.
module tb_dec_secded;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          clr_cnt = 1'b0;
    logic [31:0]   data_in = '0;
    logic [1:0]    work_mod = '0;
    logic          out_valid;
    logic [31:0]   data_out;
    logic [1:0]    num_of_errors;
    logic [CW-1:0] cnt_corrected;
    logic [CW-1:0] cnt_uncorr;

    dec_secded #(
        .MAX_CODEWORD_WIDTH(32),
        .MAX_INFO_WIDTH    (26),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .work_mod     (work_mod),
        .clr_cnt      (clr_cnt),
        .out_valid    (out_valid),
        .data_out     (data_out),
        .num_of_errors(num_of_errors),
        .cnt_corrected(cnt_corrected),
        .cnt_uncorr   (cnt_uncorr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          clr_cyc = -1;
    int          n_chk = 0;
    int          n_fail = 0;
    int          ec = 0;
    int          eu = 0;
    logic [31:0] last_d = '0;
    logic [1:0]  last_e = '0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int tn(logic [1:0] m);
        return (m == 2'b01) ? 8 : (m == 2'b10) ? 16 : 32;
    endfunction

    function automatic int tk(logic [1:0] m);
        return (m == 2'b01) ? 4 : (m == 2'b10) ? 11 : 26;
    endfunction

    function automatic logic [31:0] enc(logic [31:0] info, int n);
        logic [31:0] cw;
        int idx;
        logic x;
        cw  = '0;
        idx = 0;
        for (int p = 1; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = info[idx];
                idx++;
            end
        end
        for (int b = 1; b < n; b = b * 2) begin
            x = 1'b0;
            for (int p = 1; p < n; p++) begin
                if ((p & b) != 0 && p != b) x = x ^ cw[p-1];
            end
            cw[b-1] = x;
        end
        cw[n-1] = ^cw;
        return cw;
    endfunction

    function automatic logic [31:0] ext(logic [31:0] cw, int n);
        logic [31:0] r;
        int idx;
        r   = '0;
        idx = 0;
        for (int p = 1; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                r[idx] = cw[p-1];
                idx++;
            end
        end
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            if (cyc == clr_cyc) begin
                ec = 0;
                eu = 0;
            end
            if (out_valid) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("data_out", data_out, e.data);
                    chk("num_err", 32'(num_of_errors), 32'(e.err));
                    last_d = e.data;
                    last_e = e.err;
                    if (cyc != clr_cyc) begin
                        if (e.err == 2'd1 && ec != CMAX) ec++;
                        if (e.err == 2'd2 && eu != CMAX) eu++;
                    end
                end
            end else begin
                chk("hold_data", data_out, last_d);
                chk("hold_err", 32'(num_of_errors), 32'(last_e));
            end
            chk("cnt_corr", 32'(cnt_corrected), ec);
            chk("cnt_uncorr", 32'(cnt_uncorr), eu);
        end
    end

    task automatic drive(logic v, logic [1:0] m, logic [31:0] d,
                         logic c, logic [31:0] xd, logic [1:0] xe);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        work_mod = m;
        data_in  = d;
        clr_cnt  = c;
        if (c) clr_cyc = cyc + 1;
        if (v) begin
            e.data = xd;
            e.err  = xe;
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 2'd0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #3;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_data", data_out, 0);
        chk("rst_err", 32'(num_of_errors), 0);
        chk("rst_cc", 32'(cnt_corrected), 0);
        chk("rst_cu", 32'(cnt_uncorr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        drive(1, 2'b01, 32'h55, 0, 32'hB, 2'd0);
        drive(1, 2'b01, 32'h45, 0, 32'hB, 2'd1);
        drive(1, 2'b01, 32'hD5, 0, 32'hB, 2'd1);
        drive(1, 2'b01, 32'h56, 0, 32'hB, 2'd2);
        idle();
        idle();

        drive(1, 2'b01, 32'hFFFF_FF55, 0, 32'hB, 2'd0);
        drive(1, 2'b11, 32'h0, 0, 32'h0, 2'd0);
        drive(1, 2'b00, 32'h1234, 0, 32'h0, 2'd3);
        drive(1, 2'b10, enc(32'h5A5, 16), 0, 32'h5A5, 2'd0);
        idle();
        idle();
        idle();

        // reset one cycle after a word is accepted
        drive(1, 2'b01, 32'h45, 0, 32'hB, 2'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        ec     = 0;
        eu     = 0;
        last_d = '0;
        last_e = '0;
        #2;
        chk("mid_rst_ov", 32'(out_valid), 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_err", 32'(num_of_errors), 0);
        chk("mid_rst_cc", 32'(cnt_corrected), 0);
        chk("mid_rst_cu", 32'(cnt_uncorr), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) idle();

        drive(1, 2'b01, 32'h45, 0, 32'hB, 2'd1);
        drive(1, 2'b01, 32'h56, 0, 32'hB, 2'd2);
        drive(1, 2'b01, 32'h45, 0, 32'hB, 2'd1);
        drive(0, 2'b00, 32'h0, 1, 32'h0, 2'd0);
        idle();
        idle();

        for (int i = 0; i < 90; i++) begin
            logic [1:0]  m;
            logic [31:0] info, cw, msk, d, xd;
            logic [1:0]  xe;
            int          n, k, inj, b0, b1;
            m = 2'($urandom_range(0, 3));
            if (m == 2'b00) begin
                d  = $urandom;
                xd = '0;
                xe = 2'd3;
            end else begin
                n    = tn(m);
                k    = tk(m);
                info = $urandom & ((32'd1 << k) - 1);
                cw   = enc(info, n);
                inj  = $urandom_range(0, 2);
                b0   = $urandom_range(0, n - 1);
                b1   = (b0 + $urandom_range(1, n - 1)) % n;
                if (inj >= 1) cw[b0] = ~cw[b0];
                if (inj == 2) cw[b1] = ~cw[b1];
                xd  = (inj == 2) ? ext(cw, n) : info;
                xe  = 2'(inj);
                msk = (n == 32) ? '1 : ((32'd1 << n) - 1);
                d   = cw | ($urandom & ~msk);
            end
            drive(1, m, d, 0, xd, xe);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
